// File: rtl/axi_stream_mux_scheduler.sv
// Packet-aware round-robin scheduler for a registered AXI-stream mux.
// Holds the mux select for one whole packet, with a beat-limit watchdog.
module axi_stream_mux_scheduler #(
  parameter int N_INPUTS   = 5,
  parameter int ADDR_WIDTH = 3,
  parameter int MAX_BEATS  = 256,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [N_INPUTS-1:0]   request,
  input  logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  out_last,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [N_INPUTS-1:0]   grant,
  output logic                  active,
  output logic                  overrun
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    BUSY   = 2'd2
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] last_grant;
  logic [CNT_WIDTH-1:0]  beats;

  logic                  win_found;
  logic [ADDR_WIDTH-1:0] win_idx;
  logic [ADDR_WIDTH-1:0] pos;

  logic                  beat;
  logic [CNT_WIDTH-1:0]  beats_nxt;
  logic                  limit_hit;

  // Round-robin search: first requester above last_grant, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    pos       = '0;
    for (int k = 1; k <= N_INPUTS; k++) begin
      pos = ADDR_WIDTH'((int'(last_grant) + k) % N_INPUTS);
      if (!win_found && request[pos]) begin
        win_found = 1'b1;
        win_idx   = pos;
      end
    end
  end

  // Beat detection, saturating count and watchdog limit.
  always_comb begin
    beat      = out_valid & out_ready;
    beats_nxt = (&beats) ? beats : beats + 1'b1;
    limit_hit = (MAX_BEATS != 0) &&
                (beats_nxt == CNT_WIDTH'(MAX_BEATS));
  end

  // Scheduler FSM with registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      address    <= '0;
      grant      <= '0;
      active     <= 1'b0;
      overrun    <= 1'b0;
      beats      <= '0;
      last_grant <= ADDR_WIDTH'(N_INPUTS - 1);
    end else begin
      overrun <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enable && win_found) begin
            address    <= win_idx;
            grant      <= N_INPUTS'(1) << win_idx;
            active     <= 1'b1;
            last_grant <= win_idx;
            beats      <= '0;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          state <= BUSY;
        end
        BUSY: begin
          if (beat) begin
            beats <= beats_nxt;
            if (out_last || limit_hit) begin
              grant   <= '0;
              active  <= 1'b0;
              overrun <= ~out_last;
              state   <= IDLE;
            end
          end
        end
        default: begin
          state  <= IDLE;
          grant  <= '0;
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_stream_mux_scheduler.sv
// Randomized scoreboard bench for axi_stream_mux_scheduler.
// A packet-level reference model predicts every cycle's outputs.
module tb_axi_stream_mux_scheduler;

  localparam int N  = 5;
  localparam int AW = 3;
  localparam int MB = 6;
  localparam int CW = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic [N-1:0]  request;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic [AW-1:0] address;
  logic [N-1:0]  grant;
  logic          active;
  logic          overrun;

  axi_stream_mux_scheduler #(
    .N_INPUTS  (N),
    .ADDR_WIDTH(AW),
    .MAX_BEATS (MB),
    .CNT_WIDTH (CW)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .request  (request),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .address  (address),
    .grant    (grant),
    .active   (active),
    .overrun  (overrun)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [N-1:0]  gnt;
    logic          act;
    logic          ovr;
  } exp_t;

  exp_t expq[$];
  int compared   = 0;
  int mismatched = 0;

  // Reference model: who owns the output, and how many beats it has sent.
  int owner    = -1;
  bit in_settle = 1'b0;
  int sent     = 0;
  int lastg    = N - 1;
  int m_addr   = 0;
  bit m_ovr    = 1'b0;

  always @(posedge clock) begin : model
    exp_t e;
    if (reset) begin
      owner = -1;
      in_settle = 1'b0;
      sent = 0;
      lastg = N - 1;
      m_addr = 0;
      m_ovr = 1'b0;
    end else begin
      m_ovr = 1'b0;
      if (owner < 0) begin
        if (enable && request != 0) begin
          for (int k = 1; k <= N; k++)
            if (owner < 0 && request[(lastg + k) % N])
              owner = (lastg + k) % N;
          m_addr = owner;
          lastg = owner;
          sent = 0;
          in_settle = 1'b1;
        end
      end else if (in_settle) begin
        in_settle = 1'b0;
      end else if (out_valid && out_ready) begin
        sent++;
        if (out_last) begin
          owner = -1;
        end else if (MB != 0 && sent == MB) begin
          owner = -1;
          m_ovr = 1'b1;
        end
      end
    end
    e.addr = AW'(m_addr);
    e.gnt  = (owner >= 0) ? (N'(1) << owner) : '0;
    e.act  = (owner >= 0);
    e.ovr  = m_ovr;
    expq.push_back(e);
  end

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %0d expected %0d",
               name, $time, act, exp);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest prediction.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      check("address", int'(address), int'(e.addr));
      check("grant", int'(grant), int'(e.gnt));
      check("active", int'(active), int'(e.act));
      check("overrun", int'(overrun), int'(e.ovr));
    end
  end

  task automatic drive(input int n, input int p_last, input int p_en,
                       input int p_rst, input bit all_req,
                       input bit one_req);
    for (int c = 0; c < n; c++) begin
      @(posedge clock);
      #1;
      if (all_req)
        request = '1;
      else if (one_req)
        request = N'(1) << ($urandom % N);
      else
        request = N'($urandom);
      enable    = ($urandom % 100) < p_en;
      reset     = ($urandom % 100) < p_rst;
      out_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      out_last  = ($urandom % 100) < p_last;
    end
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    request   = '0;
    out_valid = 1'b0;
    out_ready = 1'b0;
    out_last  = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    // Single requester, normal packets.
    drive(100, 30, 100, 0, 1'b0, 1'b1);
    // All inputs requesting: rotation through every index.
    drive(300, 40, 100, 0, 1'b1, 1'b0);
    // Random request mixes with moderate packet lengths.
    drive(400, 25, 100, 0, 1'b0, 1'b0);
    // Never-ending packets: watchdog releases.
    drive(300, 0, 100, 0, 1'b0, 1'b0);
    // Limit and tlast often coinciding.
    drive(300, 12, 100, 0, 1'b0, 1'b0);
    // Enable toggling and sporadic resets mid-packet.
    drive(600, 15, 50, 3, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    reset     = 1'b0;
    request   = '0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
